// File: rtl/branch_predictor_if.sv
// Bundle of lookup, update and statistics signals for the branch predictor.
//   master : fetch/execute side -- drives req_* and upd_*, observes pred_* and stat_*
//   slave  : predictor side     -- consumes req_* and upd_*, drives pred_* and stat_*
//   req_valid/req_pc     lookup request (pc[1:0] ignored for indexing)
//   pred_valid/taken/target  prediction, one cycle after the request
//   upd_valid/pc/taken/target/mispredict  resolved conditional branch
//   stat_branches/stat_mispredict  running counts since reset
interface branch_predictor_if #(
    parameter int CNT_W = 32
);
    logic             req_valid;
    logic [31:0]      req_pc;
    logic             pred_valid;
    logic             pred_taken;
    logic [31:0]      pred_target;
    logic             upd_valid;
    logic [31:0]      upd_pc;
    logic             upd_taken;
    logic [31:0]      upd_target;
    logic             upd_mispredict;
    logic [CNT_W-1:0] stat_branches;
    logic [CNT_W-1:0] stat_mispredict;

    modport master (
        output req_valid, req_pc,
        output upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
        input  pred_valid, pred_taken, pred_target,
        input  stat_branches, stat_mispredict
    );

    modport slave (
        input  req_valid, req_pc,
        input  upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
        output pred_valid, pred_taken, pred_target,
        output stat_branches, stat_mispredict
    );
endinterface

// File: rtl/branch_predictor.sv
// Fetch-side dynamic branch predictor: direct-mapped BTB with a 2-bit
// saturating direction counter per entry, plus branch/mispredict counters.
//   clk  clock
//   rst  synchronous reset, active high; overrides lookup/update that cycle
//   bp   branch_predictor_if.slave
//        lookup: req_valid/req_pc -> pred_valid/pred_taken/pred_target (1 cycle)
//        update: upd_valid/upd_pc/upd_taken/upd_target/upd_mispredict
//        stats : stat_branches, stat_mispredict (wrap modulo 2^CNT_W)
// Counter encoding: 00 strongly-not-taken, 01 weakly-not-taken,
//                   10 weakly-taken, 11 strongly-taken.
module branch_predictor #(
    parameter int ENTRIES = 64,
    parameter int CNT_W   = 32
) (
    input logic               clk,
    input logic               rst,
    branch_predictor_if.slave bp
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 32 - IDX_W - 2;

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [31:0]       target_q [ENTRIES];
    logic [1:0]        ctr_q    [ENTRIES];

    logic [IDX_W-1:0]  ridx;
    logic [TAG_W-1:0]  rtag;
    logic              lk_taken;
    logic [IDX_W-1:0]  uidx;
    logic [TAG_W-1:0]  utag;
    logic              upd_hit;
    logic [1:0]        ctr_next;

    logic              pred_valid_q;
    logic              pred_taken_q;
    logic [31:0]       pred_target_q;
    logic [CNT_W-1:0]  stat_br_q;
    logic [CNT_W-1:0]  stat_mp_q;

    assign ridx = bp.req_pc[IDX_W+1:2];
    assign rtag = bp.req_pc[31:IDX_W+2];
    assign uidx = bp.upd_pc[IDX_W+1:2];
    assign utag = bp.upd_pc[31:IDX_W+2];

    // Lookup reads the tables as they stand before this edge's update,
    // which gives read-before-write when both touch the same index.
    assign lk_taken = valid_q[ridx] && (tag_q[ridx] == rtag) && ctr_q[ridx][1];
    assign upd_hit  = valid_q[uidx] && (tag_q[uidx] == utag);

    always_comb begin
        ctr_next = ctr_q[uidx];
        if (bp.upd_taken && (ctr_q[uidx] != 2'b11)) begin
            ctr_next = ctr_q[uidx] + 2'b01;
        end else if (!bp.upd_taken && (ctr_q[uidx] != 2'b00)) begin
            ctr_next = ctr_q[uidx] - 2'b01;
        end
    end

    // Prediction register: taken/target hold while no request is presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= 32'h0;
        end else if (bp.req_valid) begin
            pred_valid_q  <= 1'b1;
            pred_taken_q  <= lk_taken;
            pred_target_q <= lk_taken ? target_q[ridx] : bp.req_pc + 32'd4;
        end else begin
            pred_valid_q  <= 1'b0;
        end
    end

    // Only the valid bits need clearing; stale tag/target/ctr are masked.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (bp.upd_valid && (upd_hit || bp.upd_taken)) begin
            valid_q[uidx] <= 1'b1;
        end
    end

    // A not-taken miss leaves the table untouched; a taken miss allocates
    // (evicting any alias at that index) straight into weakly-taken.
    always_ff @(posedge clk) begin
        if (!rst && bp.upd_valid) begin
            if (upd_hit) begin
                ctr_q[uidx] <= ctr_next;
                if (bp.upd_taken) begin
                    target_q[uidx] <= bp.upd_target;
                end
            end else if (bp.upd_taken) begin
                tag_q[uidx]    <= utag;
                target_q[uidx] <= bp.upd_target;
                ctr_q[uidx]    <= 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else if (bp.upd_valid) begin
            stat_br_q <= stat_br_q + 1'b1;
            if (bp.upd_mispredict) begin
                stat_mp_q <= stat_mp_q + 1'b1;
            end
        end
    end

    assign bp.pred_valid      = pred_valid_q;
    assign bp.pred_taken      = pred_taken_q;
    assign bp.pred_target     = pred_target_q;
    assign bp.stat_branches   = stat_br_q;
    assign bp.stat_mispredict = stat_mp_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (ENTRIES=64, CNT_W=32).
module tb_branch_predictor;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    branch_predictor_if #(.CNT_W(32)) bp ();

    branch_predictor #(.ENTRIES(64), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bp.req_valid      = 1'b0;
        bp.req_pc         = 32'h0;
        bp.upd_valid      = 1'b0;
        bp.upd_pc         = 32'h0;
        bp.upd_taken      = 1'b0;
        bp.upd_target     = 32'h0;
        bp.upd_mispredict = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] pc);
        bp.req_valid = 1'b1;
        bp.req_pc    = pc;
        tick();
        bp.req_valid = 1'b0;
    endtask

    task automatic update(input logic [31:0] pc, input logic taken,
                          input logic [31:0] tgt, input logic mis);
        bp.upd_valid      = 1'b1;
        bp.upd_pc         = pc;
        bp.upd_taken      = taken;
        bp.upd_target     = tgt;
        bp.upd_mispredict = mis;
        tick();
        bp.upd_valid      = 1'b0;
        bp.upd_mispredict = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst           = 1'b1;
        bp.req_valid  = 1'b1;
        bp.req_pc     = 32'h100;
        bp.upd_valid  = 1'b1;
        bp.upd_pc     = 32'h100;
        bp.upd_taken  = 1'b1;
        bp.upd_target = 32'h40;
        bp.upd_mispredict = 1'b1;
        tick();
        idle_inputs();
        rst = 1'b0;
        checks++;
        if (bp.pred_valid !== 1'b0) begin
            errors++; $display("FAIL reset_pred_valid got=%0b exp=0", bp.pred_valid);
        end
        checks++;
        if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h0) begin
            errors++; $display("FAIL reset_pred got taken=%0b target=%h exp 0/00000000",
                               bp.pred_taken, bp.pred_target);
        end
        checks++;
        if (bp.stat_branches !== 32'd0 || bp.stat_mispredict !== 32'd0) begin
            errors++; $display("FAIL reset_stats got br=%0d mp=%0d exp 0/0",
                               bp.stat_branches, bp.stat_mispredict);
        end
        // The update seen during reset must not have trained 0x100.
        lookup(32'h100);
        checks++;
        if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h104) begin
            errors++; $display("FAIL reset_blocks_update got taken=%0b target=%h exp 0/00000104",
                               bp.pred_taken, bp.pred_target);
        end
    endtask

    task automatic test_cold_lookup();
        do_reset();
        lookup(32'h100);
        checks++;
        if (bp.pred_valid !== 1'b1 || bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h104) begin
            errors++; $display("FAIL cold_lookup got v=%0b taken=%0b target=%h exp 1/0/00000104",
                               bp.pred_valid, bp.pred_taken, bp.pred_target);
        end
        tick();
        checks++;
        if (bp.pred_valid !== 1'b0) begin
            errors++; $display("FAIL idle_pred_valid got=%0b exp=0", bp.pred_valid);
        end
    endtask

    task automatic test_train();
        do_reset();
        update(32'h100, 1'b1, 32'h40, 1'b0);
        lookup(32'h100);
        checks++;
        if (bp.pred_valid !== 1'b1 || bp.pred_taken !== 1'b1 || bp.pred_target !== 32'h40) begin
            errors++; $display("FAIL train_taken got v=%0b taken=%0b target=%h exp 1/1/00000040",
                               bp.pred_valid, bp.pred_taken, bp.pred_target);
        end
        tick();
        checks++;
        if (bp.pred_valid !== 1'b0 || bp.pred_taken !== 1'b1 || bp.pred_target !== 32'h40) begin
            errors++; $display("FAIL pred_hold got v=%0b taken=%0b target=%h exp 0/1/00000040",
                               bp.pred_valid, bp.pred_taken, bp.pred_target);
        end
        update(32'h100, 1'b0, 32'h999, 1'b0);
        lookup(32'h100);
        checks++;
        if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h104) begin
            errors++; $display("FAIL train_weak_nt got taken=%0b target=%h exp 0/00000104",
                               bp.pred_taken, bp.pred_target);
        end
    endtask

    task automatic test_saturation();
        logic       dir  [9];
        logic       etkn [9];
        logic [8:0] dir_v;
        logic [8:0] etkn_v;
        logic [31:0] etgt;
        // Counter path 10,11,11,11 then 10,01,00,00,00.
        dir_v  = 9'b000001111;
        etkn_v = 9'b000011111;
        for (int i = 0; i < 9; i++) begin
            dir[i]  = dir_v[i];
            etkn[i] = etkn_v[i];
        end
        do_reset();
        for (int i = 0; i < 9; i++) begin
            update(32'h200, dir[i], dir[i] ? 32'h80 : 32'hDEAD, 1'b0);
            lookup(32'h200);
            etgt = etkn[i] ? 32'h80 : 32'h204;
            checks++;
            if (bp.pred_taken !== etkn[i] || bp.pred_target !== etgt) begin
                errors++; $display("FAIL saturation step=%0d got taken=%0b target=%h exp %0b/%h",
                                   i, bp.pred_taken, bp.pred_target, etkn[i], etgt);
            end
        end
        // Only one taken update needed to flip back out of 00 is wrong: 00->01 stays not-taken.
        update(32'h200, 1'b1, 32'h84, 1'b0);
        lookup(32'h200);
        checks++;
        if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h204) begin
            errors++; $display("FAIL sat_recover got taken=%0b target=%h exp 0/00000204",
                               bp.pred_taken, bp.pred_target);
        end
    endtask

    task automatic test_alias();
        do_reset();
        update(32'h100, 1'b1, 32'h40, 1'b0);
        update(32'h200, 1'b1, 32'h80, 1'b0);
        lookup(32'h100);
        checks++;
        if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h104) begin
            errors++; $display("FAIL alias_evicted got taken=%0b target=%h exp 0/00000104",
                               bp.pred_taken, bp.pred_target);
        end
        lookup(32'h200);
        checks++;
        if (bp.pred_taken !== 1'b1 || bp.pred_target !== 32'h80) begin
            errors++; $display("FAIL alias_new got taken=%0b target=%h exp 1/00000080",
                               bp.pred_taken, bp.pred_target);
        end
        // Not-taken miss of an alias must not disturb the resident entry.
        update(32'h100, 1'b0, 32'h0, 1'b0);
        lookup(32'h200);
        checks++;
        if (bp.pred_taken !== 1'b1 || bp.pred_target !== 32'h80) begin
            errors++; $display("FAIL alias_nt_miss got taken=%0b target=%h exp 1/00000080",
                               bp.pred_taken, bp.pred_target);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        bp.req_valid  = 1'b1;
        bp.req_pc     = 32'h300;
        bp.upd_valid  = 1'b1;
        bp.upd_pc     = 32'h300;
        bp.upd_taken  = 1'b1;
        bp.upd_target = 32'hC0;
        tick();
        bp.upd_valid  = 1'b0;
        checks++;
        if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h304) begin
            errors++; $display("FAIL same_cycle_old got taken=%0b target=%h exp 0/00000304",
                               bp.pred_taken, bp.pred_target);
        end
        tick();
        bp.req_valid = 1'b0;
        checks++;
        if (bp.pred_valid !== 1'b1 || bp.pred_taken !== 1'b1 || bp.pred_target !== 32'hC0) begin
            errors++; $display("FAIL same_cycle_next got v=%0b taken=%0b target=%h exp 1/1/000000c0",
                               bp.pred_valid, bp.pred_taken, bp.pred_target);
        end
        lookup(32'hFFFF_FFFC);
        checks++;
        if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h0) begin
            errors++; $display("FAIL pc_wrap got taken=%0b target=%h exp 0/00000000",
                               bp.pred_taken, bp.pred_target);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pcs  [4];
        logic        etkn [4];
        logic [31:0] etgt [4];
        pcs[0] = 32'h300; etkn[0] = 1'b1; etgt[0] = 32'hC0;
        pcs[1] = 32'h304; etkn[1] = 1'b0; etgt[1] = 32'h308;
        pcs[2] = 32'h500; etkn[2] = 1'b0; etgt[2] = 32'h504;
        pcs[3] = 32'h300; etkn[3] = 1'b1; etgt[3] = 32'hC0;
        bp.req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bp.req_pc = pcs[i];
            tick();
            checks++;
            if (bp.pred_valid !== 1'b1 || bp.pred_taken !== etkn[i] || bp.pred_target !== etgt[i]) begin
                errors++; $display("FAIL back_to_back i=%0d got v=%0b taken=%0b target=%h exp 1/%0b/%h",
                                   i, bp.pred_valid, bp.pred_taken, bp.pred_target, etkn[i], etgt[i]);
            end
        end
        bp.req_valid = 1'b0;
    endtask

    task automatic test_stats();
        logic mis;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            mis = (i == 1) || (i == 4) || (i == 7);
            update(32'h400 + 32'(4 * i), (i % 2) == 0, 32'h1000 + 32'(i), mis);
        end
        checks++;
        if (bp.stat_branches !== 32'd10 || bp.stat_mispredict !== 32'd3) begin
            errors++; $display("FAIL stats_count got br=%0d mp=%0d exp 10/3",
                               bp.stat_branches, bp.stat_mispredict);
        end
        bp.upd_mispredict = 1'b1;
        tick();
        tick();
        bp.upd_mispredict = 1'b0;
        checks++;
        if (bp.stat_branches !== 32'd10 || bp.stat_mispredict !== 32'd3) begin
            errors++; $display("FAIL stats_ignore_mp got br=%0d mp=%0d exp 10/3",
                               bp.stat_branches, bp.stat_mispredict);
        end
        lookup(32'h400);
        checks++;
        if (bp.pred_taken !== 1'b1 || bp.pred_target !== 32'h1000) begin
            errors++; $display("FAIL stats_trained got taken=%0b target=%h exp 1/00001000",
                               bp.pred_taken, bp.pred_target);
        end
        rst               = 1'b1;
        bp.upd_valid      = 1'b1;
        bp.upd_pc         = 32'h400;
        bp.upd_taken      = 1'b1;
        bp.upd_mispredict = 1'b1;
        tick();
        idle_inputs();
        rst = 1'b0;
        checks++;
        if (bp.stat_branches !== 32'd0 || bp.stat_mispredict !== 32'd0) begin
            errors++; $display("FAIL stats_reset got br=%0d mp=%0d exp 0/0",
                               bp.stat_branches, bp.stat_mispredict);
        end
        lookup(32'h400);
        checks++;
        if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h404) begin
            errors++; $display("FAIL reset_forgets got taken=%0b target=%h exp 0/00000404",
                               bp.pred_taken, bp.pred_target);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        idle_inputs();
        tick();
        test_reset();
        test_cold_lookup();
        test_train();
        test_saturation();
        test_alias();
        test_same_cycle();
        test_back_to_back();
        test_stats();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
